// File: rtl/corr2_pkg.sv
// Shared constants and types for the correlation_2_dot kernel.
//   N_TAPS  number of x/h operand pairs
//   DATA_W  width of each unsigned operand
//   PROD_W  width of one unsigned product (2*DATA_W)
//   OUT_W   width of the exact correlation sum
package corr2_pkg;
  localparam int N_TAPS = 10;
  localparam int DATA_W = 4;
  localparam int PROD_W = 2 * DATA_W;
  localparam int OUT_W  = 12;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]  sum_t;
endpackage

// File: rtl/corr2_mul.sv
// Unsigned DATA_W x DATA_W multiplier producing a full-width product.
// Ports:
//   a  in   DATA_W  unsigned sample operand
//   b  in   DATA_W  unsigned coefficient operand
//   p  out  PROD_W  exact unsigned product
module corr2_mul
  import corr2_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output prod_t             p
);
  assign p = prod_t'(a) * prod_t'(b);
endmodule

// File: rtl/correlation_2_dot.sv
// Unsigned 10-tap correlation engine: out = sum(x_i * h_i), i = 0..9.
// All operands are sampled together; the result is registered. No handshake.
// Optional build macro CORR2_PIPE_EN inserts a product register stage between
// the multipliers and the adder tree (latency 2 instead of 1).
// Ports:
//   out       out  OUT_W   registered correlation result
//   clock     in   1       rising-edge clock
//   reset     in   1       synchronous active-low reset, clears all stages
//   x_0..x_9  in   DATA_W  unsigned sample operands
//   h_0..h_9  in   DATA_W  unsigned coefficient operands
module correlation_2_dot
  import corr2_pkg::*;
(
  output sum_t              out,
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_0,
  input  logic [DATA_W-1:0] x_1,
  input  logic [DATA_W-1:0] x_2,
  input  logic [DATA_W-1:0] x_3,
  input  logic [DATA_W-1:0] x_4,
  input  logic [DATA_W-1:0] x_5,
  input  logic [DATA_W-1:0] x_6,
  input  logic [DATA_W-1:0] x_7,
  input  logic [DATA_W-1:0] x_8,
  input  logic [DATA_W-1:0] x_9,
  input  logic [DATA_W-1:0] h_0,
  input  logic [DATA_W-1:0] h_1,
  input  logic [DATA_W-1:0] h_2,
  input  logic [DATA_W-1:0] h_3,
  input  logic [DATA_W-1:0] h_4,
  input  logic [DATA_W-1:0] h_5,
  input  logic [DATA_W-1:0] h_6,
  input  logic [DATA_W-1:0] h_7,
  input  logic [DATA_W-1:0] h_8,
  input  logic [DATA_W-1:0] h_9
);

  logic [N_TAPS-1:0][DATA_W-1:0] x_vec;
  logic [N_TAPS-1:0][DATA_W-1:0] h_vec;
  prod_t [N_TAPS-1:0]            prod_c;
  prod_t [N_TAPS-1:0]            tree_in;

  assign x_vec = {x_9, x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};
  assign h_vec = {h_9, h_8, h_7, h_6, h_5, h_4, h_3, h_2, h_1, h_0};

  for (genvar i = 0; i < N_TAPS; i++) begin : g_mul
    corr2_mul u_mul (
      .a (x_vec[i]),
      .b (h_vec[i]),
      .p (prod_c[i])
    );
  end

`ifdef CORR2_PIPE_EN
  // ---- stage p0: registered products ----
  prod_t [N_TAPS-1:0] prod_p0;

  always_ff @(posedge clock) begin
    if (!reset) prod_p0 <= '0;
    else        prod_p0 <= prod_c;
  end

  assign tree_in = prod_p0;
`else
  assign tree_in = prod_c;
`endif

  // Adder tree 10 -> 5 -> 3 -> 2 -> 1, one extra bit per level so the sum is exact.
  logic [PROD_W:0]   lvl1 [5];
  logic [PROD_W+1:0] lvl2 [3];
  logic [PROD_W+2:0] lvl3 [2];
  sum_t              sum_c;

  for (genvar j = 0; j < 5; j++) begin : g_lvl1
    assign lvl1[j] = (PROD_W+1)'(tree_in[2*j]) + (PROD_W+1)'(tree_in[2*j+1]);
  end

  // Odd leftovers at each level are just widened and carried forward.
  assign lvl2[0] = (PROD_W+2)'(lvl1[0]) + (PROD_W+2)'(lvl1[1]);
  assign lvl2[1] = (PROD_W+2)'(lvl1[2]) + (PROD_W+2)'(lvl1[3]);
  assign lvl2[2] = (PROD_W+2)'(lvl1[4]);

  assign lvl3[0] = (PROD_W+3)'(lvl2[0]) + (PROD_W+3)'(lvl2[1]);
  assign lvl3[1] = (PROD_W+3)'(lvl2[2]);

  assign sum_c = sum_t'(lvl3[0]) + sum_t'(lvl3[1]);

  // ---- output stage: registered result ----
  always_ff @(posedge clock) begin
    if (!reset) out <= '0;
    else        out <= sum_c;
  end

endmodule

// File: tb/tb_correlation_2_dot.sv
module tb_correlation_2_dot;
  import corr2_pkg::*;

`ifdef CORR2_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] xs [N_TAPS];
  logic [DATA_W-1:0] hs [N_TAPS];
  sum_t              out;

  int n_checks = 0;
  int n_fail   = 0;

  correlation_2_dot dut (
    .out   (out),
    .clock (clock),
    .reset (reset),
    .x_0 (xs[0]), .x_1 (xs[1]), .x_2 (xs[2]), .x_3 (xs[3]), .x_4 (xs[4]),
    .x_5 (xs[5]), .x_6 (xs[6]), .x_7 (xs[7]), .x_8 (xs[8]), .x_9 (xs[9]),
    .h_0 (hs[0]), .h_1 (hs[1]), .h_2 (hs[2]), .h_3 (hs[3]), .h_4 (hs[4]),
    .h_5 (hs[5]), .h_6 (hs[6]), .h_7 (hs[7]), .h_8 (hs[8]), .h_9 (hs[9])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result after an edge is the plain dot product of the
  // operands captured LAT edges earlier, provided reset was high on all of the
  // last LAT edges; otherwise it is zero.
  int  dot_hist [LAT];
  int  run_len  = 0;
  int  exp_out  = 0;
  bit  model_ok = 0;

  function automatic int dot_now();
    int s = 0;
    for (int i = 0; i < N_TAPS; i++) s += int'(xs[i]) * int'(hs[i]);
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      for (int k = LAT-1; k > 0; k--) dot_hist[k] = dot_hist[k-1];
      dot_hist[0] = dot_now();
      if (reset === 1'b0) run_len = 0;
      else                run_len++;
      exp_out  = (run_len >= LAT) ? dot_hist[LAT-1] : 0;
      model_ok = 1;
    end
  end

  // Stream compare against the model on every cycle once the model is primed.
  initial begin
    forever begin
      @(negedge clock);
      if (model_ok) check("stream", int'(out), exp_out);
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < N_TAPS; i++) begin
      xs[i] = DATA_W'($urandom_range(0, 15));
      hs[i] = DATA_W'($urandom_range(0, 15));
    end
  endtask

  task automatic set_all(input int xv, input int hv);
    for (int i = 0; i < N_TAPS; i++) begin
      xs[i] = DATA_W'(xv);
      hs[i] = DATA_W'(hv);
    end
  endtask

  // Hold current operands for LAT edges, then check the literal result.
  task automatic hold_and_check(input string name, input int exp);
    repeat (LAT) @(negedge clock);
    check(name, int'(out), exp);
  endtask

  initial begin
    reset = 1'b0;
    rand_ops();

    // Reset held low for two edges with random operands.
    @(negedge clock);
    check("reset_edge1", int'(out), 0);
    rand_ops();
    @(negedge clock);
    check("reset_edge2", int'(out), 0);

    reset = 1'b1;
    set_all(15, 15);
    hold_and_check("max_2250", 2250);

    for (int i = 0; i < N_TAPS; i++) begin
      xs[i] = DATA_W'(i);
      hs[i] = DATA_W'(1);
    end
    hold_and_check("ramp_45", 45);
    for (int i = 0; i < N_TAPS; i++) hs[i] = DATA_W'(i);
    hold_and_check("square_285", 285);

    set_all(0, 0);
    xs[3] = 4'd7;
    hs[3] = 4'd9;
    hold_and_check("single_63", 63);
    set_all(0, 0);
    xs[9] = 4'd9;
    hs[8] = 4'd15;
    hold_and_check("disjoint_0", 0);

    // Random stream with a one-edge reset pulse in the middle.
    for (int c = 0; c < 1000; c++) begin
      rand_ops();
      if (c == 500) begin
        reset = 1'b0;
        @(negedge clock);
        check("mid_reset", int'(out), 0);
        reset = 1'b1;
        rand_ops();
        // Set a known vector so recovery is checked against a literal too.
        set_all(15, 15);
        hold_and_check("recover_2250", 2250);
      end else begin
        @(negedge clock);
      end
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
